// File: rtl/multi_cycle_ctrl_if.sv
// Handshake and strobe bundle between the multi-cycle control FSM and the datapath.
// master = control FSM side, slave = datapath/memory side.
interface multi_cycle_ctrl_if;
    logic [31:0] inst;
    logic        imem_rdy;
    logic        dmem_rdy;
    logic        br_taken;
    logic [4:0]  state;
    logic        ir_wen;
    logic        pc_wen;
    logic [1:0]  pc_sel;
    logic        rf_wen;
    logic        rf_wdest_rd;
    logic        wb_sel_mem;
    logic        dm_ren;
    logic [3:0]  dm_wen;
    logic        inst_retire;
    logic        illegal_inst;
    logic        mem_timeout;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    modport master (
        input  inst, imem_rdy, dmem_rdy, br_taken,
        output state, ir_wen, pc_wen, pc_sel, rf_wen, rf_wdest_rd, wb_sel_mem,
               dm_ren, dm_wen, inst_retire, illegal_inst, mem_timeout,
               cycle_cnt, retire_cnt
    );

    modport slave (
        output inst, imem_rdy, dmem_rdy, br_taken,
        input  state, ir_wen, pc_wen, pc_sel, rf_wen, rf_wdest_rd, wb_sel_mem,
               dm_ren, dm_wen, inst_retire, illegal_inst, mem_timeout,
               cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for the 16-instruction MIPS subset (IF/ID/EX/MEM/WB).
// Define MULTI_CYCLE_CTRL_PERF_CNT_EN to build the cycle/retire performance counters.
//
//   state | meaning
//   IF    | wait for imem_rdy, load IR
//   ID    | decode; J and illegal finish here
//   EX    | ALU op; branches resolve and finish here
//   MEM   | LW/SW data RAM access, wait for dmem_rdy
//   WB    | register file write, PC += 4
module multi_cycle_ctrl #(
    parameter int WAIT_MAX = 0,
    parameter int WAIT_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    multi_cycle_ctrl_if.master   bus
);

    localparam logic [4:0] S_IF  = 5'b00001;
    localparam logic [4:0] S_ID  = 5'b00010;
    localparam logic [4:0] S_EX  = 5'b00100;
    localparam logic [4:0] S_MEM = 5'b01000;
    localparam logic [4:0] S_WB  = 5'b10000;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    logic [4:0] state_q, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;

    logic [5:0] op, funct;
    logic [4:0] sa;
    logic is_alu_r, is_shift, is_r, is_addiu, is_lui, is_beq, is_bne;
    logic is_lw, is_sw, is_j, is_branch, is_illegal;
    logic waiting, timeout, wait_clr;
    logic unused_inst_bits;

    assign op    = bus.inst[31:26];
    assign sa    = bus.inst[10:6];
    assign funct = bus.inst[5:0];
    assign unused_inst_bits = ^bus.inst[25:11];

    assign is_alu_r  = (op == 6'b000000) && (sa == 5'd0) &&
                       (funct inside {6'b100001, 6'b100011, 6'b101010, 6'b100100,
                                      6'b100111, 6'b100101, 6'b100110});
    assign is_shift  = (op == 6'b000000) && ((funct == 6'b000000) || (funct == 6'b000010));
    assign is_r      = is_alu_r | is_shift;
    assign is_addiu  = (op == 6'b001001);
    assign is_lui    = (op == 6'b001111);
    assign is_beq    = (op == 6'b000100);
    assign is_bne    = (op == 6'b000101);
    assign is_lw     = (op == 6'b100011);
    assign is_sw     = (op == 6'b101011);
    assign is_j      = (op == 6'b000010);
    assign is_branch = is_beq | is_bne;
    assign is_illegal = !(is_r | is_addiu | is_lui | is_branch | is_lw | is_sw | is_j);

    // Ready inputs only matter in their own wait state.
    assign waiting = ((state_q == S_IF)  && !bus.imem_rdy) ||
                     ((state_q == S_MEM) && !bus.dmem_rdy);
    assign timeout = (WAIT_MAX != 0) && waiting && (wait_cnt >= WAIT_LIM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IF;
        else         state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IF:  if (bus.imem_rdy) state_nxt = S_ID;
            S_ID:  state_nxt = (is_illegal || is_j) ? S_IF : S_EX;
            S_EX: begin
                if (is_branch)           state_nxt = S_IF;
                else if (is_lw || is_sw) state_nxt = S_MEM;
                else                     state_nxt = S_WB;
            end
            S_MEM: begin
                if (bus.dmem_rdy) state_nxt = is_lw ? S_WB : S_IF;
                else if (timeout) state_nxt = S_IF;
            end
            S_WB:  state_nxt = S_IF;
            default: state_nxt = S_IF;
        endcase
    end

    // A timeout re-entering IF from IF counts as a fresh entry.
    assign wait_clr = ((state_nxt == S_IF)  && ((state_q != S_IF) || timeout)) ||
                      ((state_nxt == S_MEM) && (state_q != S_MEM));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                      wait_cnt <= '0;
        else if (wait_clr)                wait_cnt <= '0;
        else if (waiting && !(&wait_cnt)) wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    logic       o_ir_wen, o_pc_wen, o_rf_wen, o_wdest_rd, o_wb_mem, o_dm_ren;
    logic       o_retire, o_illegal, o_timeout;
    logic [1:0] o_pc_sel;
    logic [3:0] o_dm_wen;

    always_comb begin
        o_ir_wen   = 1'b0;
        o_pc_wen   = 1'b0;
        o_pc_sel   = PC_SEQ;
        o_rf_wen   = 1'b0;
        o_wdest_rd = 1'b0;
        o_wb_mem   = 1'b0;
        o_dm_ren   = 1'b0;
        o_dm_wen   = 4'h0;
        o_retire   = 1'b0;
        o_illegal  = 1'b0;
        o_timeout  = 1'b0;
        if (resetn) begin
            case (state_q)
                S_IF: begin
                    o_ir_wen  = bus.imem_rdy;
                    o_timeout = timeout;
                end
                S_ID: begin
                    if (is_illegal) begin
                        o_illegal = 1'b1;
                        o_pc_wen  = 1'b1;
                    end else if (is_j) begin
                        o_pc_wen = 1'b1;
                        o_pc_sel = PC_J;
                        o_retire = 1'b1;
                    end
                end
                S_EX: begin
                    if (is_branch) begin
                        o_pc_wen = 1'b1;
                        o_pc_sel = bus.br_taken ? PC_BR : PC_SEQ;
                        o_retire = 1'b1;
                    end
                end
                S_MEM: begin
                    if (timeout) begin
                        o_timeout = 1'b1;
                        o_pc_wen  = 1'b1;
                    end else begin
                        o_dm_ren = is_lw;
                        o_dm_wen = is_sw ? 4'hF : 4'h0;
                        if (bus.dmem_rdy && is_sw) begin
                            o_pc_wen = 1'b1;
                            o_retire = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    o_rf_wen   = 1'b1;
                    o_pc_wen   = 1'b1;
                    o_retire   = 1'b1;
                    o_wdest_rd = is_r;
                    o_wb_mem   = is_lw;
                end
                default: ;
            endcase
        end
    end

    assign bus.state        = resetn ? state_q : 5'b00000;
    assign bus.ir_wen       = o_ir_wen;
    assign bus.pc_wen       = o_pc_wen;
    assign bus.pc_sel       = o_pc_sel;
    assign bus.rf_wen       = o_rf_wen;
    assign bus.rf_wdest_rd  = o_wdest_rd;
    assign bus.wb_sel_mem   = o_wb_mem;
    assign bus.dm_ren       = o_dm_ren;
    assign bus.dm_wen       = o_dm_wen;
    assign bus.inst_retire  = o_retire;
    assign bus.illegal_inst = o_illegal;
    assign bus.mem_timeout  = o_timeout;

`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
    logic [31:0] cycle_q, retire_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_q  <= 32'd0;
            retire_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (o_retire) retire_q <= retire_q + 32'd1;
        end
    end

    assign bus.cycle_cnt  = cycle_q;
    assign bus.retire_cnt = retire_q;
`else
    assign bus.cycle_cnt  = 32'd0;
    assign bus.retire_cnt = 32'd0;
`endif

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Control FSM that runs the 16-instruction MIPS subset datapath as a multi-cycle CPU: IF, ID, EX, MEM, WB.
- Sits between the instruction register, register file, ALU and data RAM. It drives all write strobes, PC select and retire pulses.
- Memories may have variable latency through ready handshakes, so instructions take between 2 and 5+ cycles.

Parameters:
WAIT_MAX, 0, max cycles spent waiting for imem_rdy/dmem_rdy before abort; 0 = wait forever
WAIT_W, 8, width of wait counter; WAIT_MAX < 2^WAIT_W

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
inst  in  32  current instruction from IR; stable outside IF
imem_rdy  in  1  instruction fetch data valid this cycle
dmem_rdy  in  1  data RAM access complete this cycle
br_taken  in  1  datapath compare result (BEQ: rs==rt, BNE: rs!=rt)
state  out  5  one-hot state: IF=00001 ID=00010 EX=00100 MEM=01000 WB=10000
ir_wen  out  1  load IR
pc_wen  out  1  update PC
pc_sel  out  2  00 seq (pc+4), 01 branch target, 10 jump target
rf_wen  out  1  register file write
rf_wdest_rd  out  1  1 = write rd, 0 = write rt
wb_sel_mem  out  1  1 = writeback from dm_rdata
dm_ren  out  1  data RAM read request
dm_wen  out  4  data RAM byte write enables
inst_retire  out  1  one-cycle pulse per completed instruction
illegal_inst  out  1  one-cycle pulse on undecodable instruction
mem_timeout  out  1  one-cycle pulse on wait abort
cycle_cnt  out  32  optional perf counter
retire_cnt  out  32  optional perf counter

Behaviour:
- Decode uses MIPS encoding.
  - R-type: op=0, sa=0 for ADDU/SUBU/SLT/AND/NOR/OR/XOR. funct 100001/100011/101010/100100/100111/100101/100110.
  - SLL/SRL: op=0, funct 000000/000010, any sa.
  - ADDIU 001001, BEQ 000100, BNE 000101, LW 100011, SW 101011, LUI 001111, J 000010.
  - All other encodings are illegal. 0x00000000 decodes as SLL and is legal.
- State register resets asynchronously to IF. Wait counter and perf counters reset to 0.
- All outputs are combinational from state, inst and the ready inputs, and are forced 0 while resetn=0. This includes dm_wen and rf_wen, with no glitch into memory during reset.
- IF: ir_wen=imem_rdy. Stay in IF while !imem_rdy. Go to ID on the first cycle with imem_rdy=1.
- ID:
  - Illegal: illegal_inst=1, pc_wen=1, pc_sel=00, then IF. No retire.
  - J: pc_wen=1, pc_sel=10, inst_retire=1, then IF.
  - Otherwise go to EX.
- EX:
  - BEQ/BNE: pc_wen=1, pc_sel = br_taken ? 01 : 00, inst_retire=1, then IF.
  - LW/SW: go to MEM.
  - All others: go to WB.
- MEM, LW: dm_ren=1 every cycle until dmem_rdy. On dmem_rdy go to WB.
- MEM, SW: dm_wen=4'hF every cycle until dmem_rdy. On dmem_rdy: pc_wen=1, pc_sel=00, inst_retire=1, then IF.
- WB:
  - rf_wen=1, pc_wen=1, pc_sel=00, inst_retire=1, then IF.
  - rf_wdest_rd=1 for R-type; 0 for ADDIU/LUI/LW.
  - wb_sel_mem=1 only for LW.
- Latency with zero-wait memory: J 2, BEQ/BNE 3, ALU/LUI/ADDIU 4, SW 4, LW 5 cycles.
- pc_wen and inst_retire are asserted exactly once per instruction. illegal_inst and mem_timeout retire nothing.
- imem_rdy is ignored outside IF. dmem_rdy is ignored outside MEM.
- br_taken is sampled only in EX for BEQ/BNE.
- Wait counter:
  - Clears on entry to IF or MEM.
  - Increments each cycle spent in IF with !imem_rdy, or in MEM with !dmem_rdy.
  - If WAIT_MAX != 0 and the counter reaches WAIT_MAX with ready still low: mem_timeout=1, go to IF.
  - On a MEM abort also pc_wen=1, pc_sel=00, with no rf_wen, dm_wen or retire on that cycle.
  - The counter saturates and never wraps.
- Ready arriving on the same cycle the counter reaches WAIT_MAX counts as success, not timeout.
- Reset asserted mid-instruction: strobes drop immediately and the FSM restarts in IF. The partial instruction is neither retired nor committed.

Optional Feature:
MULTI_CYCLE_CTRL_PERF_CNT_EN
- Defined: cycle_cnt increments every clock out of reset. retire_cnt increments on each inst_retire. Both wrap 0xFFFFFFFF -> 0 and reset to 0.
- Undefined: both ports are tied to 32'd0, with no counter logic.

Test Plan:
- ADDU 0x00221821, imem_rdy=dmem_rdy=1 -> states IF,ID,EX,WB. In the WB cycle: rf_wen=1, rf_wdest_rd=1, pc_sel=00, pc_wen=1, inst_retire=1, each high for exactly one cycle.
- LW 0x8C230004, dmem_rdy low for 3 MEM cycles -> dm_ren high 4 cycles. Then WB with rf_wen=1, rf_wdest_rd=0, wb_sel_mem=1. Total 8 cycles, retire_cnt +1.
- BEQ 0x10220003, br_taken=1 -> EX pc_sel=01, pc_wen=1. Repeat with br_taken=0 -> pc_sel=00. Each takes 3 cycles, no rf_wen.
- J 0x08000010 -> ID pc_wen=1, pc_sel=10, retire. Back in IF on cycle 3. Illegal 0xFC000000 -> ID illegal_inst=1, pc_sel=00, no retire or rf_wen.
- SW 0xAC230008, reset pulsed low in the 2nd MEM cycle -> dm_wen goes to 0 asynchronously. After release: state=00001, no retire counted.
- WAIT_MAX=4, imem_rdy held 0 -> mem_timeout pulses once after 4 IF wait cycles, FSM stays in IF. With PERF_CNT_EN, cycle_cnt preloaded near 0xFFFFFFFF wraps to 0.
